button_debounce: RTL and testbench

Debounces the on-board push buttons. Each raw input passes through a two-flop synchronizer and a per-button stability counter, which produce a clean level plus single-cycle press and release pulses. An optional hold timer adds a long-press pulse. The block sits between the board button pins and user logic such as LED pattern selection, and is the input-side counterpart of the LED driver.

---
 rtl/button_debounce.sv | 135 +++++++++++++
 tb/tb_button_debounce.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop sync, per-button stability counter, press/release pulses.
// Define BUTTON_LONG_PRESS_EN to build the per-button hold FSM that drives btn_long.
module button_debounce #(
  parameter int unsigned CLOCK_XTAL    = 27000000,
  parameter int unsigned BTN_NUM       = 2,
  parameter bit          BTN_ACTIVE    = 1'b1,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BTN_NUM-1:0] btns,
  output logic [BTN_NUM-1:0] btn_level,
  output logic [BTN_NUM-1:0] btn_press,
  output logic [BTN_NUM-1:0] btn_release,
  output logic [BTN_NUM-1:0] btn_long
);

  localparam int unsigned DbRaw    = CLOCK_XTAL / 1000 * DEBOUNCE_MS;
  localparam int unsigned DbCycles = (DbRaw < 1) ? 1 : DbRaw;
  localparam int unsigned DbW      = $clog2(DbCycles + 1);

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LongRaw    = CLOCK_XTAL / 1000 * LONG_PRESS_MS;
  localparam int unsigned LongCycles = (LongRaw < 1) ? 1 : LongRaw;
  localparam int unsigned LongW      = $clog2(LongCycles + 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } hold_state_e;
`endif

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_btn
    logic           sync1_q, sync2_q;
    logic           s;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;

    // Normalised so that 1 always means pressed.
    assign s = (sync2_q == BTN_ACTIVE);

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DbW'(DbCycles - 1)) begin
        level_d = s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q   <= ~BTN_ACTIVE;
        sync2_q   <= ~BTN_ACTIVE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= btns[i];
        sync2_q   <= sync1_q;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

`ifdef BUTTON_LONG_PRESS_EN
    hold_state_e      state_q, state_d;
    logic [LongW-1:0] hcnt_q, hcnt_d;
    logic             long_q, long_d;

    // A release on the threshold edge takes priority over the long pulse.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      long_d  = 1'b0;
      case (state_q)
        StIdle: begin
          if (press_d) begin
            state_d = StPressed;
            hcnt_d  = '0;
          end
        end
        StPressed: begin
          if (release_d) begin
            state_d = StIdle;
          end else if (hcnt_q == LongW'(LongCycles - 1)) begin
            long_d  = 1'b1;
            state_d = StHeld;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (release_d) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= StIdle;
        hcnt_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        long_q  <= long_d;
      end
    end

    assign btn_long[i] = long_q;
`else
    assign btn_long[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: vector table, directed corner sequences and
// randomised stimulus against a sample-window reference model.
module tb_button_debounce;

  localparam int unsigned NB   = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 20;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btns;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

  button_debounce #(
    .CLOCK_XTAL   (1000),
    .BTN_NUM      (NB),
    .BTN_ACTIVE   (1'b1),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btns       (btns),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the last DB synchronised samples all disagree with it.
  bit m_sync1[NB], m_sync2[NB];
  bit m_win[NB][DB];
  bit m_level[NB], m_press[NB], m_rel[NB], m_long[NB], m_armed[NB];
  int m_age[NB];

  task automatic model_step();
    for (int b = 0; b < NB; b++) begin
      if (!rst_n) begin
        m_sync1[b] = 0; m_sync2[b] = 0;
        for (int k = 0; k < DB; k++) m_win[b][k] = 0;
        m_level[b] = 0; m_press[b] = 0; m_rel[b] = 0; m_long[b] = 0;
        m_armed[b] = 0; m_age[b] = 0;
      end else begin
        bit flip;
        for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = m_sync2[b];
        flip = 1;
        for (int k = 0; k < DB; k++) if (m_win[b][k] == m_level[b]) flip = 0;
        m_press[b] = flip && !m_level[b];
        m_rel[b]   = flip && m_level[b];
        if (flip) m_level[b] = !m_level[b];
        m_long[b] = 0;
        if (m_press[b]) begin
          m_age[b] = 0; m_armed[b] = 1;
        end else if (m_rel[b]) begin
          m_armed[b] = 0;
        end else if (m_armed[b] && m_level[b]) begin
          m_age[b]++;
          if (m_age[b] == LONG) begin
            m_long[b] = 1; m_armed[b] = 0;
          end
        end
        m_sync2[b] = m_sync1[b];
        m_sync1[b] = (btns[b] == 1'b1);
      end
    end
  endtask

  task automatic tick();
    logic [NB-1:0] el, ep, er, eg;
    model_step();
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) begin
      el[b] = m_level[b]; ep[b] = m_press[b]; er[b] = m_rel[b];
      eg[b] = LongEn ? m_long[b] : 1'b0;
    end
    check("model_level", int'(btn_level), int'(el));
    check("model_press", int'(btn_press), int'(ep));
    check("model_release", int'(btn_release), int'(er));
    check("model_long", int'(btn_long), int'(eg));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [NB-1:0] btns;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n_press, n_rel, n_long, p_at, l_at, r_at, ok;

    for (int i = 0; i < 8; i++) begin
      tbl[i].btns  = 2'b01;
      tbl[i].level = (i >= 5) ? 2'b01 : 2'b00;
      tbl[i].press = (i == 5) ? 2'b01 : 2'b00;
    end

    rst_n = 1'b0;
    btns  = '0;
    idle(3);
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(btn_press), 0);
    check("reset_release", int'(btn_release), 0);
    check("reset_long", int'(btn_long), 0);
    rst_n = 1'b1;
    idle(6);

    // Clean press: level and press pulse 6 edges after the raw change
    for (int i = 0; i < 8; i++) begin
      btns = tbl[i].btns;
      tick();
      check("tbl_level", int'(btn_level), int'(tbl[i].level));
      check("tbl_press", int'(btn_press), int'(tbl[i].press));
    end
    btns = '0;
    idle(10);

    // Bounce: high 3, low 1, then steady high
    n_press = 0; p_at = -1;
    for (int n = 1; n <= 20; n++) begin
      btns = (n == 4) ? 2'b00 : 2'b01;
      tick();
      if (btn_press[0]) begin n_press++; p_at = n; end
    end
    check("bounce_press_count", n_press, 1);
    check("bounce_press_edge", p_at, 10);
    btns = '0;
    idle(10);

    // Long press: hold 30 cycles past the press, then release
    btns = 2'b01;
    p_at = -1;
    for (int n = 1; n <= 10 && p_at < 0; n++) begin
      tick();
      if (btn_press[0]) p_at = n;
    end
    check("long_press_seen", p_at, 6);
    n_long = 0; l_at = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (btn_long[0]) begin n_long++; l_at = n; end
    end
    btns = '0;
    n_rel = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (btn_long[0]) n_long++;
      if (btn_release[0]) n_rel++;
    end
    check("long_count", n_long, LongEn ? 1 : 0);
    check("long_offset", l_at, LongEn ? LONG : -1);
    check("long_release_count", n_rel, 1);
    idle(4);

    // Short press: released 10 cycles after the press
    btns = 2'b01;
    p_at = -1;
    for (int n = 1; n <= 10 && p_at < 0; n++) begin
      tick();
      if (btn_press[0]) p_at = n;
    end
    check("short_press_seen", p_at, 6);
    idle(10);
    btns = '0;
    n_long = 0; n_rel = 0; r_at = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (btn_long[0]) n_long++;
      if (btn_release[0]) begin n_rel++; r_at = n; end
    end
    check("short_long_count", n_long, 0);
    check("short_release_count", n_rel, 1);
    check("short_release_edge", r_at, 6);

    // Simultaneous press on both buttons
    btns = 2'b11;
    ok = 0; n_press = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (btn_press == 2'b11) ok++;
      if (btn_press != 2'b00) n_press++;
    end
    check("simul_press_both", ok, 1);
    check("simul_press_cycles", n_press, 1);
    btns = '0;
    idle(10);

    // Reset 10 cycles into a hold, button kept pressed through reset
    btns = 2'b01;
    p_at = -1;
    for (int n = 1; n <= 10 && p_at < 0; n++) begin
      tick();
      if (btn_press[0]) p_at = n;
    end
    check("rst_hold_press_seen", p_at, 6);
    idle(10);
    rst_n = 1'b0;
    tick();
    check("rst_hold_level", int'(btn_level), 0);
    check("rst_hold_press", int'(btn_press), 0);
    check("rst_hold_release", int'(btn_release), 0);
    check("rst_hold_long", int'(btn_long), 0);
    rst_n = 1'b1;
    p_at = -1;
    for (int n = 1; n <= 12 && p_at < 0; n++) begin
      tick();
      if (btn_press[0]) p_at = n;
    end
    check("rst_hold_repress_edge", p_at, 6);
    btns = '0;
    idle(10);

    // Randomised stimulus with varying bounce density and occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned odds;
      case (blk % 3)
        0:       odds = 3;
        1:       odds = 8;
        default: odds = 40;
      endcase
      for (int n = 0; n < 200; n++) begin
        for (int b = 0; b < NB; b++)
          if ($urandom_range(odds - 1) == 0) btns[b] = ~btns[b];
        rst_n = ($urandom_range(699) != 0);
        tick();
      end
    end
    rst_n = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
